inv_substitution_layer_iter: RTL and testbench
==============================================

// Module: inv_substitution_layer_iter
// PURPOSE
//  Iterative inverse of the Ascon 5-bit S-box layer (NIST SP 800-232).
//  - Accepts one 320-bit ascon_state_t over a valid/ready handshake.
//  - Applies the inverse S-box to COLS_PER_CYCLE bit-sliced columns per clock.
//  - Returns the fully inverted state over a second valid/ready handshake.
//  - Used by the inverse-permutation datapath and as a round-trip checker against the forward substitution layer.
// PARAMETERS
//  COLS_PER_CYCLE  8  columns (bit positions j) transformed per RUN cycle; must divide WORD_WIDTH (64)
// PORTS
//  clk_i        in   1              clock; all logic on rising edge
//  rst_ni       in   1              reset, synchronous, active-low
//  in_valid_i   in   1              state_i valid
//  in_ready_o   out  1              block can accept a state
//  state_i      in   ascon_state_t  input state, words [0..4] x 64 bits
//  out_valid_o  out  1              state_o valid
//  out_ready_i  in   1              downstream accepts state_o
//  state_o      out  ascon_state_t  inverse-substituted state
//  busy_o       out  1              high in RUN or DONE
//  err_o        out  1              sticky self-check mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Column convention
//   - Column j = {s[0][j],s[1][j],s[2][j],s[3][j],s[4][j]}; word 0 is the MSB.
//   - Output column = ASCON_INV_SBOX[column], with ASCON_INV_SBOX[ASCON_SBOX[x]] == x for all x.
//  Working register
//   - One 320-bit register; state_o is driven directly from it.
//   - Chunk counter cnt: width $clog2(N), where N = WORD_WIDTH/COLS_PER_CYCLE.
//  FSM IDLE/RUN/DONE
//   - IDLE: in_ready_o=1. On in_valid_i&&in_ready_o: load state_i, cnt<=0, ->RUN.
//   - RUN: in_ready_o=0. Each cycle, columns [cnt*C +: C] of all 5 words are replaced in place; cnt++.
//     On the cycle that processes chunk cnt==N-1: cnt<=0, ->DONE.
//   - DONE: out_valid_o=1; state_o stable. On out_ready_i: ->IDLE.
//     in_ready_o=0 in DONE; no accept in the same cycle as the output handshake.
//  Timing and ordering
//   - Latency: out_valid_o rises N clock edges after the accepting edge (N=8 by default).
//   - Throughput: one state per N+2 cycles minimum.
//   - Chunk order is ascending j; untouched columns hold their loaded values.
//   - out_valid_o stays high and state_o holds while out_ready_i=0 (no timeout).
//   - out_ready_i is ignored outside DONE; in_valid_i is ignored outside IDLE.
//  Reset (rst_ni=0 at a clock edge)
//   - FSM->IDLE, cnt=0, working register=0, err_o=0.
//   - Outputs after reset: in_ready_o=1, out_valid_o=0, busy_o=0, state_o=0.
//   - Reset during RUN or DONE aborts the operation; no partial output is ever presented.
// CONFIGURATION
//  Macro ASCON_INV_SBOX_SELFCHECK_EN
//  - Defined:
//    - Each RUN cycle the forward S-box is applied to the C freshly produced columns.
//    - The result is compared against the pre-transform columns.
//    - Any mismatch sets err_o=1 (sticky).
//    - err_o clears on reset or on the next input accept.
//    - err_o is valid by the time out_valid_o rises.
//  - Undefined: no forward S-box is instantiated; err_o is tied 0. The port list is identical in both builds.
// STRUCTURE
//  ascon_pkg additions:
//  - ASCON_SBOX and ASCON_INV_SBOX as 32x5-bit localparam LUTs.
//  - inv_sbox_state_e enum {IDLE,RUN,DONE}.
//  - The existing NUM_WORDS, WORD_WIDTH and ascon_state_t are reused.
//  Sub-module inv_sbox_col:
//  - Purely combinational: 5-bit column in, 5-bit inverse column out.
//  - Instantiated COLS_PER_CYCLE times in a generate loop.
//  - Column select uses cnt*COLS_PER_CYCLE as the part-select base.
// TESTING
//  1. Zero state: state_i all-zero -> after 8 cycles state_o = {64'hFFFF_FFFF_FFFF_FFFF,64'h0,64'hFFFF_FFFF_FFFF_FFFF,64'h0,64'h0}
//     (every column 0x00 -> INV 0x14).
//  2. All-ones state: state_i all words 64'hFFFF_FFFF_FFFF_FFFF (every column 0x1F) -> every output column 0x02:
//     s[3]=all-ones, other words 0.
//  3. Round trip: 1000 random states through forward substitution then this block -> state_o == original;
//     also check mixed-column states (e.g. j-dependent patterns) so chunk placement is exercised.
//  4. Backpressure: hold out_ready_i=0 for 20 cycles in DONE -> out_valid_o=1, state_o constant, in_ready_o=0;
//     release -> IDLE next cycle, in_ready_o=1.
//  5. Reset mid-RUN: assert rst_ni=0 at cnt=3 -> next cycle out_valid_o=0, in_ready_o=1, state_o=0;
//     a new state then completes correctly in 8 cycles.
//  6. Self-check (macro defined): force one inv_sbox_col output bit during RUN -> err_o=1 at out_valid_o;
//     next accept clears it. Macro undefined: err_o==0 throughout all tests.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared Ascon state types plus the forward/inverse 5-bit S-box tables.
// Consumed by inv_substitution_layer_iter and its inv_sbox_col columns.
package ascon_pkg;

  localparam int NUM_WORDS  = 5;
  localparam int WORD_WIDTH = 64;

  typedef logic [WORD_WIDTH-1:0] ascon_state_t [NUM_WORDS];

  localparam logic [4:0] ASCON_SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [4:0] ASCON_INV_SBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} inv_sbox_state_e;

endpackage

// File: rtl/inv_sbox_col.sv
// Combinational inverse Ascon S-box for one bit-sliced column (word 0 is bit 4).
module inv_sbox_col
  import ascon_pkg::*;
(
  input  logic [4:0] col_i,
  output logic [4:0] col_o
);

  assign col_o = ASCON_INV_SBOX[col_i];

endmodule

// File: rtl/inv_substitution_layer_iter.sv
// Iterative inverse Ascon S-box layer, COLS_PER_CYCLE columns per RUN cycle.
// Optional forward-S-box self-check selected by macro ASCON_INV_SBOX_SELFCHECK_EN.
module inv_substitution_layer_iter
  import ascon_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  ascon_state_t state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output ascon_state_t state_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam int N     = WORD_WIDTH / COLS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = $clog2(WORD_WIDTH);

  inv_sbox_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ascon_state_t data_q, data_d;
  logic [IDX_W-1:0] base;
  logic [COLS_PER_CYCLE-1:0][NUM_WORDS-1:0] col_in, col_out;

  assign base = IDX_W'(cnt_q) * IDX_W'(COLS_PER_CYCLE);

  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        col_in[k][NUM_WORDS-1-w] = data_q[w][base + IDX_W'(k)];
      end
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    inv_sbox_col u_col (
      .col_i (col_in[k]),
      .col_o (col_out[k])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          data_d  = state_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Only the current chunk is rewritten; all other columns keep their values.
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          for (int w = 0; w < NUM_WORDS; w++) begin
            data_d[w][base + IDX_W'(k)] = col_out[k][NUM_WORDS-1-w];
          end
        end
        if (cnt_q == CNT_W'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign state_o = data_q;
  assign busy_o  = (state_q == RUN) || (state_q == DONE);

`ifdef ASCON_INV_SBOX_SELFCHECK_EN
  logic err_q, err_d, mismatch, accept;

  assign accept = in_valid_i && in_ready_o;

  // Re-encrypt each freshly inverted column and compare with what went in.
  always_comb begin
    mismatch = 1'b0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      if (ASCON_SBOX[col_out[k]] != col_in[k]) begin
        mismatch = 1'b1;
      end
    end
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if ((state_q == RUN) && mismatch) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_inv_substitution_layer_iter.sv
// Self-checking bench for inv_substitution_layer_iter: table vectors, random
// round trips through a Boolean-equation forward S-box model, and corner sequences.
module tb_inv_substitution_layer_iter;
  import ascon_pkg::*;

  localparam int C = 8;
  localparam int N = WORD_WIDTH / C;

  logic clk_i = 1'b0;
  logic rst_ni, in_valid_i, in_ready_o, out_valid_o, out_ready_i, busy_o, err_o;
  ascon_state_t state_i, state_o;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [4:0] inv_ref [32];

  typedef struct packed {
    logic [319:0] in_v;
    logic [319:0] exp_v;
  } vec_t;

  inv_substitution_layer_iter #(.COLS_PER_CYCLE(C)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .state_i     (state_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .state_o     (state_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Forward Ascon S-box from its bit-sliced Boolean description.
  function automatic logic [4:0] fwd5(input logic [4:0] v);
    logic x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = v;
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] pack(input ascon_state_t s);
    return {s[0], s[1], s[2], s[3], s[4]};
  endfunction

  function automatic ascon_state_t unpack(input logic [319:0] v);
    ascon_state_t r;
    {r[0], r[1], r[2], r[3], r[4]} = v;
    return r;
  endfunction

  function automatic ascon_state_t model_map(input ascon_state_t s, input bit inverse);
    ascon_state_t r;
    logic [4:0] c, o;
    for (int j = 0; j < WORD_WIDTH; j++) begin
      c = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      o = inverse ? inv_ref[c] : fwd5(c);
      {r[0][j], r[1][j], r[2][j], r[3][j], r[4][j]} = o;
    end
    return r;
  endfunction

  function automatic ascon_state_t col_pattern(input int mul, input int add);
    ascon_state_t r;
    logic [4:0] c;
    for (int j = 0; j < WORD_WIDTH; j++) begin
      c = 5'(j * mul + add);
      {r[0][j], r[1][j], r[2][j], r[3][j], r[4][j]} = c;
    end
    return r;
  endfunction

  function automatic ascon_state_t rand_state();
    ascon_state_t r;
    for (int w = 0; w < NUM_WORDS; w++) r[w] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string name, input ascon_state_t act, input ascon_state_t exp);
    tests_run++;
    if (pack(act) !== pack(exp)) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, pack(act), pack(exp));
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic applyStimulus(input ascon_state_t s);
    int k = 0;
    while (in_ready_o !== 1'b1 && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    if (k == 50) checkVal("in_ready timeout", {63'd0, in_ready_o}, 64'd1);
    in_valid_i = 1'b1;
    state_i    = s;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    for (int w = 0; w < NUM_WORDS; w++) state_i[w] = ~s[w];
  endtask

  task automatic waitValid(input string name);
    int lat = 0;
    while (out_valid_o !== 1'b1 && lat < 4 * N) begin
      @(negedge clk_i);
      lat++;
    end
    checkVal({name, " latency"}, 64'(lat), 64'(N));
  endtask

  task automatic checkOutput(input string name, input ascon_state_t exp, input logic exp_err);
    waitValid(name);
    checkVal({name, " busy"}, {63'd0, busy_o}, 64'd1);
    checkState({name, " state"}, state_o, exp);
    checkVal({name, " err"}, {63'd0, err_o}, {63'd0, exp_err});
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    checkVal({name, " idle"}, {61'd0, in_ready_o, out_valid_o, busy_o}, 64'b100);
  endtask

  initial begin
    vec_t vecs [6];
    ascon_state_t zero_s, ones_s, rs, exp_s;
    bit hold_ok;

    for (int x = 0; x < 32; x++) inv_ref[fwd5(5'(x))] = 5'(x);
    zero_s = '{default: '0};
    ones_s = '{default: '1};

    vecs[0] = '{in_v: pack(zero_s),
                exp_v: {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0}};
    vecs[1] = '{in_v: pack(ones_s),
                exp_v: {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0}};
    vecs[2] = '{in_v: pack(col_pattern(1, 0)),  exp_v: pack(model_map(col_pattern(1, 0), 1'b1))};
    vecs[3] = '{in_v: pack(col_pattern(7, 3)),  exp_v: pack(model_map(col_pattern(7, 3), 1'b1))};
    vecs[4] = '{in_v: pack(col_pattern(13, 17)), exp_v: pack(model_map(col_pattern(13, 17), 1'b1))};
    vecs[5] = '{in_v: pack(col_pattern(0, 9)),  exp_v: pack(model_map(col_pattern(0, 9), 1'b1))};

    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; state_i = zero_s;
    @(negedge clk_i);
    @(negedge clk_i);
    checkVal("reset flags", {60'd0, in_ready_o, out_valid_o, busy_o, err_o}, 64'b1000);
    checkState("reset state", state_o, zero_s);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(unpack(vecs[i].in_v));
      checkOutput($sformatf("vec%0d", i), unpack(vecs[i].exp_v), 1'b0);
    end

    // Round trip: forward model then DUT must reproduce the original.
    for (int i = 0; i < 1000; i++) begin
      rs = rand_state();
      applyStimulus(model_map(rs, 1'b0));
      out_ready_i = 1'($urandom_range(0, 1));
      checkOutput("roundtrip", rs, 1'b0);
    end

    // Backpressure: hold DONE for 20 cycles.
    rs = rand_state();
    exp_s = model_map(rs, 1'b1);
    applyStimulus(rs);
    waitValid("bp");
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || pack(state_o) !== pack(exp_s)) hold_ok = 1'b0;
    end
    checkVal("bp hold", {63'd0, hold_ok}, 64'd1);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    checkVal("bp release", {62'd0, in_ready_o, out_valid_o}, 64'b10);

    // Reset while cnt==3 in RUN.
    applyStimulus(rand_state());
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    checkVal("midrun reset flags", {61'd0, in_ready_o, out_valid_o, busy_o}, 64'b100);
    checkState("midrun reset state", state_o, zero_s);
    rs = rand_state();
    applyStimulus(rs);
    checkOutput("after reset", model_map(rs, 1'b1), 1'b0);

`ifdef ASCON_INV_SBOX_SELFCHECK_EN
    applyStimulus(zero_s);
    force dut.col_out = '0;
    @(negedge clk_i);
    release dut.col_out;
    waitValid("selfcheck");
    checkVal("selfcheck err set", {63'd0, err_o}, 64'd1);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    applyStimulus(ones_s);
    checkVal("selfcheck err cleared", {63'd0, err_o}, 64'd0);
    checkOutput("after selfcheck", unpack(vecs[1].exp_v), 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
